// File: rtl/sift_ctrl_pkg.sv
// Shared types and constants for the sift_feat frame controller.
// The SIFT_FRAME_TIMEOUT_EN macro enables the RUN watchdog in sift_frame_ctrl.
package sift_ctrl_pkg;

    localparam int FRAME_W      = 512;
    localparam int FRAME_H      = 512;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

    localparam int DEF_ADDR_W   = $clog2(FRAME_PIXELS);
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_KP_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } frame_state_t;

endpackage

// File: rtl/sift_ram_mux.sv
// Image RAM port mux: the host drives the RAM combinationally unless the
// core owns it, in which case the core address is routed through and the
// returned pixel is registered onto core_din.
module sift_ram_mux #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              core_owns,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_din
);

    // Route either the host write port or the core read address to the RAM
    always_comb begin
        h_ready   = !core_owns;
        ram_we    = h_we;
        ram_addr  = h_addr;
        ram_wdata = h_wdata;
        if (core_owns) begin
            ram_we    = 1'b0;
            ram_addr  = core_addr;
            ram_wdata = '0;
        end
    end

    // Register the read pixel for the core while it owns the RAM
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            core_din <= '0;
        end else if (core_owns) begin
            core_din <= ram_rdata;
        end
    end

endmodule

// File: rtl/sift_frame_ctrl.sv
// Frame scheduler and image-RAM arbiter for the sift_feat core.
// Optional RUN watchdog with ERR state: define SIFT_FRAME_TIMEOUT_EN.
module sift_frame_ctrl
    import sift_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int KP_CNT_W    = DEF_KP_CNT_W,
`ifdef SIFT_FRAME_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 4194304,
`endif
    parameter int DRAIN_CYC   = 64
) (
    input  logic                clk_sys,
    input  logic                rst_sys,
    input  logic                start,
    input  logic                abort,
    input  logic                h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    output logic                h_ready,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                core_rst_n,
    input  logic [ADDR_W-1:0]   core_addr,
    output logic [DATA_W-1:0]   core_din,
    input  logic                core_kp,
    input  logic                core_out_en,
    input  logic                core_complete1,
    input  logic                core_complete2,
    output logic                busy,
    output logic                done,
    output logic [KP_CNT_W-1:0] kp_count,
    output logic [15:0]         frame_count,
    output logic                err
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    frame_state_t     state, state_nx;
    logic             core_owns;
    logic             c1, c2;
    logic             c1_any, c2_any;
    logic             enter_run;
    logic             frame_end;
    logic [DRN_W-1:0] drain_cnt;

`ifdef SIFT_FRAME_TIMEOUT_EN
    localparam int WD_W = 23;
    logic [WD_W-1:0] wd_cnt;
`endif

    assign core_owns = (state == ST_RUN) || (state == ST_DRAIN);
    assign busy      = core_owns;
    assign enter_run = (state_nx == ST_RUN) && (state != ST_RUN);
    assign frame_end = (state == ST_DRAIN) && (state_nx == ST_DONE);

    // State register
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        c1_any   = c1 | core_complete1;
        c2_any   = c2 | core_complete2;
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (c1_any && c2_any) begin
                    state_nx = ST_DRAIN;
                end
`ifdef SIFT_FRAME_TIMEOUT_EN
                else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_nx = ST_ERR;
                end
`endif
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) state_nx = ST_DONE;
            end
`ifdef SIFT_FRAME_TIMEOUT_EN
            ST_ERR: begin
                if (start) state_nx = ST_RUN;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
        if (abort) state_nx = ST_IDLE;
    end

    // Core reset follows the next state so the core is live on the first RUN cycle
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            core_rst_n  <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            core_rst_n <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
            done       <= frame_end;
            if (frame_end) frame_count <= frame_count + 16'd1;
        end
    end

    // Sticky completion flags and the post-completion drain countdown
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            c1        <= 1'b0;
            c2        <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (enter_run) begin
                c1 <= 1'b0;
                c2 <= 1'b0;
            end else if (state == ST_RUN) begin
                c1 <= c1_any;
                c2 <= c2_any;
            end
            if ((state == ST_RUN) && (state_nx == ST_DRAIN)) begin
                drain_cnt <= DRN_W'(DRAIN_CYC - 1);
            end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
        end
    end

    // Saturating keypoint counter, cleared on frame start
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            kp_count <= '0;
        end else if (enter_run) begin
            kp_count <= '0;
        end else if (core_owns && core_out_en && core_kp && (kp_count != '1)) begin
            kp_count <= kp_count + 1'b1;
        end
    end

`ifdef SIFT_FRAME_TIMEOUT_EN
    // RUN watchdog and sticky error flag; only a start out of ERR clears err
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (enter_run) begin
                wd_cnt <= '0;
            end else if (state == ST_RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if ((state_nx == ST_ERR) && (state != ST_ERR)) begin
                err <= 1'b1;
            end else if ((state == ST_ERR) && (state_nx == ST_RUN)) begin
                err <= 1'b0;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    sift_ram_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_mux (
        .clk_sys   (clk_sys),
        .rst_sys   (rst_sys),
        .core_owns (core_owns),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_ready   (h_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .core_addr (core_addr),
        .core_din  (core_din)
    );

endmodule

// File: tb/tb_sift_frame_ctrl.sv
// Self-checking bench for sift_frame_ctrl: host-load vector table, pixel
// read-back scoreboard, and hand sequences for completion, abort, reset and
// (with SIFT_FRAME_TIMEOUT_EN) the watchdog.
module tb_sift_frame_ctrl;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 8;
    localparam int KP_CNT_W  = 16;
    localparam int DRAIN_CYC = 64;
`ifdef SIFT_FRAME_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 100;
`endif

    logic                clk_sys;
    logic                rst_sys;
    logic                start;
    logic                abort;
    logic                h_we;
    logic [ADDR_W-1:0]   h_addr;
    logic [DATA_W-1:0]   h_wdata;
    logic                h_ready;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic                core_rst_n;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_din;
    logic                core_kp;
    logic                core_out_en;
    logic                core_complete1;
    logic                core_complete2;
    logic                busy;
    logic                done;
    logic [KP_CNT_W-1:0] kp_count;
    logic [15:0]         frame_count;
    logic                err;

    sift_frame_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .KP_CNT_W    (KP_CNT_W),
`ifdef SIFT_FRAME_TIMEOUT_EN
        .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
        .DRAIN_CYC   (DRAIN_CYC)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_sys        (rst_sys),
        .start          (start),
        .abort          (abort),
        .h_we           (h_we),
        .h_addr         (h_addr),
        .h_wdata        (h_wdata),
        .h_ready        (h_ready),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .core_rst_n     (core_rst_n),
        .core_addr      (core_addr),
        .core_din       (core_din),
        .core_kp        (core_kp),
        .core_out_en    (core_out_en),
        .core_complete1 (core_complete1),
        .core_complete2 (core_complete2),
        .busy           (busy),
        .done           (done),
        .kp_count       (kp_count),
        .frame_count    (frame_count),
        .err            (err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Image RAM: clocked write, data for the presented address available
    // within the same cycle so the controller's register is the only stage
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
        logic              exp_ready;
    } host_vec_t;

    host_vec_t         hv [4];
    logic [DATA_W-1:0] model [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] sb_q [$];
    logic [ADDR_W-1:0] rd [5];
    logic [DATA_W-1:0] exp_pix;

    int checks = 0;
    int errors = 0;
    int exp_kp;
    int lat;
    int done_pulses;
    int run_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_sys);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before 100000");
        $fatal(1, "bench timeout");
    end

    initial begin
        hv[0] = '{1'b1, 18'h00010, 8'hA5, 1'b1, 18'h00010, 8'hA5, 1'b1};
        hv[1] = '{1'b1, 18'h3FFFF, 8'h5A, 1'b1, 18'h3FFFF, 8'h5A, 1'b1};
        hv[2] = '{1'b0, 18'h00002, 8'h77, 1'b0, 18'h00002, 8'h77, 1'b1};
        hv[3] = '{1'b1, 18'h00001, 8'hC3, 1'b1, 18'h00001, 8'hC3, 1'b1};
        rd[0] = 18'h00010;
        rd[1] = 18'h00020;
        rd[2] = 18'h3FFFF;
        rd[3] = 18'h00001;
        rd[4] = 18'h00010;

        rst_sys = 1'b0;
        start = 1'b0; abort = 1'b0;
        h_we = 1'b0; h_addr = '0; h_wdata = '0;
        core_addr = '0; core_kp = 1'b0; core_out_en = 1'b0;
        core_complete1 = 1'b0; core_complete2 = 1'b0;

        // Reset values
        #12;
        check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("rst_core_din", 32'(core_din), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_h_ready", 32'(h_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_kp_count", 32'(kp_count), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        next_cycle();
        rst_sys = 1'b1;
        next_cycle();

        // Host load in IDLE: combinational pass-through
        for (int i = 0; i < 4; i++) begin
            h_we = hv[i].we; h_addr = hv[i].addr; h_wdata = hv[i].wdata;
            settle();
            check("host_ram_we", 32'(ram_we), 32'(hv[i].exp_we));
            check("host_ram_addr", 32'(ram_addr), 32'(hv[i].exp_addr));
            check("host_ram_wdata", 32'(ram_wdata), 32'(hv[i].exp_wdata));
            check("host_h_ready", 32'(h_ready), 32'(hv[i].exp_ready));
            if (hv[i].we) model[hv[i].addr] = hv[i].wdata;
            next_cycle();
        end

        // Start coinciding with a host write: the write lands, then RUN
        h_we = 1'b1; h_addr = 18'h00020; h_wdata = 8'h3C; start = 1'b1;
        settle();
        check("start_write_we", 32'(ram_we), 32'd1);
        check("start_write_ready", 32'(h_ready), 32'd1);
        check("start_write_core_rst", 32'(core_rst_n), 32'd0);
        model[18'h00020] = 8'h3C;
        next_cycle();
        start = 1'b0;
        h_addr = 18'h00010; h_wdata = 8'hFF;
        settle();
        check("run_core_rst_n", 32'(core_rst_n), 32'd1);
        check("run_busy", 32'(busy), 32'd1);

        // Pixel reads: expected data queued on address, compared one cycle later
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) core_addr = rd[i];
            #1;
            if (i > 0) begin
                if (sb_q.size() == 0) begin
                    check("pix_queue_empty", 32'd0, 32'd1);
                end else begin
                    exp_pix = sb_q.pop_front();
                    check("pix_core_din", 32'(core_din), 32'(exp_pix));
                end
            end
            if (i < 5) begin
                check("pix_ram_addr", 32'(ram_addr), 32'(rd[i]));
                check("run_host_ram_we", 32'(ram_we), 32'd0);
                check("run_host_h_ready", 32'(h_ready), 32'd0);
                sb_q.push_back(model[rd[i]]);
            end
            next_cycle();
        end
        h_we = 1'b0;

        // Keypoints in RUN: 3 hits, 3 misses
        exp_kp = 0;
        for (int i = 0; i < 6; i++) begin
            core_out_en = 1'b1;
            core_kp = (i < 3);
            if (i < 3) exp_kp++;
            next_cycle();
        end
        core_out_en = 1'b0; core_kp = 1'b0;

        // start during RUN is ignored
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        settle();
        check("start_in_run_busy", 32'(busy), 32'd1);
        check("start_in_run_kp", 32'(kp_count), 32'(exp_kp));
        next_cycle();

        // complete2, then complete1 ten cycles later
        core_complete2 = 1'b1;
        next_cycle();
        core_complete2 = 1'b0;
        repeat (9) next_cycle();
        core_complete1 = 1'b1;
        next_cycle();
        core_complete1 = 1'b0;

        // DRAIN: two keypoint hits, then wait for done
        lat = -1;
        for (int d = 0; d < DRAIN_CYC + 10; d++) begin
            core_out_en = (d < 2);
            core_kp = (d < 2);
            if (d < 2) exp_kp++;
            if (d == 0) begin
                settle();
                check("drain_busy", 32'(busy), 32'd1);
            end else begin
                settle();
            end
            if (done) begin
                lat = d;
                break;
            end
            next_cycle();
        end
        core_out_en = 1'b0; core_kp = 1'b0;
        check("done_latency", 32'(lat), 32'(DRAIN_CYC));
        check("done_frame_count", 32'(frame_count), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_kp_count", 32'(kp_count), 32'(exp_kp));
        check("done_core_rst_n", 32'(core_rst_n), 32'd0);
        check("done_h_ready", 32'(h_ready), 32'd1);
        next_cycle();
        settle();
        check("done_single_pulse", 32'(done), 32'd0);
        check("done_kp_hold", 32'(kp_count), 32'd5);
        next_cycle();

        // New frame clears kp_count
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        settle();
        check("restart_kp_clear", 32'(kp_count), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        next_cycle();

        // Abort together with start mid-RUN
        core_out_en = 1'b1; core_kp = 1'b1;
        next_cycle();
        core_out_en = 1'b0; core_kp = 1'b0;
        core_complete1 = 1'b1;
        next_cycle();
        core_complete1 = 1'b0;
        abort = 1'b1; start = 1'b1;
        next_cycle();
        abort = 1'b0; start = 1'b0;
        settle();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_core_rst_n", 32'(core_rst_n), 32'd0);
        check("abort_kp_kept", 32'(kp_count), 32'd1);
        check("abort_h_ready", 32'(h_ready), 32'd1);
        done_pulses = 0;
        for (int i = 0; i < DRAIN_CYC + 8; i++) begin
            next_cycle();
            core_complete2 = (i == 2);
            settle();
            if (done) done_pulses++;
        end
        core_complete2 = 1'b0;
        check("abort_no_done", 32'(done_pulses), 32'd0);
        check("abort_frame_count", 32'(frame_count), 32'd1);
        check("abort_idle_busy", 32'(busy), 32'd0);
        next_cycle();

        // abort wins over start in IDLE
        abort = 1'b1; start = 1'b1;
        next_cycle();
        abort = 1'b0; start = 1'b0;
        settle();
        check("abort_over_start", 32'(busy), 32'd0);
        next_cycle();

        // Asynchronous reset mid-frame
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        settle();
        check("pre_reset_core_rst_n", 32'(core_rst_n), 32'd1);
        #1 rst_sys = 1'b0;
        #1;
        check("async_rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_frame_count", 32'(frame_count), 32'd0);
        check("async_rst_h_ready", 32'(h_ready), 32'd1);
        next_cycle();
        rst_sys = 1'b1;
        next_cycle();

`ifdef SIFT_FRAME_TIMEOUT_EN
        // Watchdog: no completes, ERR after TIMEOUT_CYC cycles of RUN
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        run_cyc = 0;
        for (int i = 0; i < 3 * TIMEOUT_CYC; i++) begin
            settle();
            if (err) break;
            if (busy) run_cyc++;
            next_cycle();
        end
        check("wd_err", 32'(err), 32'd1);
        check("wd_run_cycles", 32'(run_cyc), 32'(TIMEOUT_CYC));
        check("wd_core_rst_n", 32'(core_rst_n), 32'd0);
        check("wd_h_ready", 32'(h_ready), 32'd1);
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        settle();
        check("wd_restart_err", 32'(err), 32'd0);
        check("wd_restart_busy", 32'(busy), 32'd1);
        next_cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
